// File: rtl/comb_bist_pkg.sv
// Shared types and constants for the comb_bist self-test harness.
// Latency/backpressure: none (declarations only).
package comb_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [4:0] MISR_TAPS = 5'b00101;  // x^5 + x^2 + 1
   localparam int         VEC_COUNT = 64;
   localparam logic [5:0] LAST_VEC  = 6'(VEC_COUNT - 1);

   function automatic logic [4:0] misr_next(input logic [4:0] sig, input logic [4:0] din);
      return {sig[3:0], 1'b0} ^ (sig[4] ? MISR_TAPS : 5'b0) ^ din;
   endfunction

endpackage

// File: rtl/comb_bist_if.sv
// Controller and function-block side signals of comb_bist; slave = harness, master = environment.
// Latency/backpressure: none (wiring only), start/done handshake.
interface comb_bist_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [6:0] err_count;
   logic       first_fail_valid;
   logic [5:0] first_fail_vec;
   logic [4:0] signature;
   logic [5:0] vec_out;
   logic [4:0] resp_in;

   modport slave (
      input  start, resp_in,
      output busy, done, pass, err_count, first_fail_valid, first_fail_vec, signature, vec_out
   );

   modport master (
      output start, resp_in,
      input  busy, done, pass, err_count, first_fail_valid, first_fail_vec, signature, vec_out
   );
endinterface

// File: rtl/comb_bist_misr5.sv
// 5-bit MISR compressing block responses; updates on en, one cycle latency.
// Backpressure: none; clr and rst both zero the register (seed 0).
module misr5
   import comb_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [4:0] din,
   output logic [4:0] sig
);

   logic [4:0] sig_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sig_q <= 5'b0;
      end else if (en) begin
         sig_q <= misr_next(sig_q, din);
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/comb_bist.sv
// Exhaustive BIST for a 6-in/5-out combinational block: 64 vectors, SETTLE+1 cycles each.
// Backpressure: start accepted only in IDLE; done pulses once, results hold until next start.
module comb_bist
   import comb_bist_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   comb_bist_if.slave  bus
);

   state_e     state_q, state_d;
   logic [5:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] err_q, err_d;
   logic       ffv_q, ffv_d;
   logic [5:0] ffvec_q, ffvec_d;
   logic       pass_q, pass_d;
   logic       misr_clr, misr_en;
   logic [4:0] sig;

   logic a, b, c, d, e, f;
   logic [4:0] golden;

   assign {a, b, c, d, e, f} = vec_q;
   assign golden[4] = (a & b) | (c & d);
   assign golden[3] = ((a & b & c) | (d & e)) & f;
   assign golden[2] = ~((a | ~b) & ((c & d) | e));
   assign golden[1] = d & (~a | b);
   assign golden[0] = (c & ~d) | (~b & ~d) | (a & b & ~c & d);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= 6'd0;
         cnt_q   <= 4'd0;
         err_q   <= 7'd0;
         ffv_q   <= 1'b0;
         ffvec_q <= 6'd0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffvec_q <= ffvec_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      ffv_d    = ffv_q;
      ffvec_d  = ffvec_q;
      pass_d   = pass_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               err_d    = 7'd0;
               ffv_d    = 1'b0;
               ffvec_d  = 6'd0;
               pass_d   = 1'b0;
               misr_clr = 1'b1;
               vec_d    = 6'd0;
               cnt_d    = 4'(SETTLE - 1);
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_SAMPLE: begin
            misr_en = 1'b1;
            if (bus.resp_in != golden) begin
               err_d = err_q + 7'd1;
               if (!ffv_q) begin
                  ffv_d   = 1'b1;
                  ffvec_d = vec_q;
               end
            end
            // pass is made visible in the same cycle that done pulses
            if (vec_q == LAST_VEC) begin
               pass_d  = (err_d == 7'd0);
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + 6'd1;
               cnt_d   = 4'(SETTLE - 1);
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   misr5 u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr),
      .en  (misr_en),
      .din (bus.resp_in),
      .sig (sig)
   );

   assign bus.vec_out          = vec_q;
   assign bus.busy             = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
   assign bus.done             = (state_q == ST_DONE);
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_valid = ffv_q;
   assign bus.first_fail_vec   = ffvec_q;
   assign bus.signature        = sig;

endmodule
